// File: rtl/rtc_bus_pkg.sv
// Shared encodings for the RTC bus transaction sequencer.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddrSetup,
      StAddrStrobe,
      StAddrHold,
      StDataSetup,
      StDataStrobe,
      StDataHold,
      StDone
   } rtc_state_e;

   localparam logic RW_READ     = 1'b1;
   localparam logic RW_WRITE    = 1'b0;
   localparam logic AD_ADDR     = 1'b0;
   localparam logic AD_DATA     = 1'b1;
   localparam logic DIR_DRIVE   = 1'b0;
   localparam logic DIR_RELEASE = 1'b1;

endpackage

// File: rtl/rtc_phase_timer.sv
// 8-bit loadable down-counter; expire_o is high while the count is zero.
module rtc_phase_timer (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   output logic       expire_o
);

   logic [7:0] cnt_q, cnt_d;

   // Load wins; otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_controller.sv
// Two-phase (address, data) transaction sequencer for the multiplexed RTC bus.
module rtc_bus_controller
   import rtc_bus_pkg::*;
#(
   parameter int unsigned T_SETUP = 1,
   parameter int unsigned T_PULSE = 4,
   parameter int unsigned T_GAP   = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_i,
   input  logic       rw_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rdata_o,
   output logic       cs_n_o,
   output logic       rd_n_o,
   output logic       wr_n_o,
   output logic       ad_sel_o,
   output logic       buf_dir_o,
   output logic [7:0] buf_wdata_o,
   input  logic [7:0] buf_rdata_i
);

   if (T_SETUP > 255) begin : gen_bad_setup
      $error("T_SETUP out of range 0..255");
   end
   if (T_PULSE < 1 || T_PULSE > 255) begin : gen_bad_pulse
      $error("T_PULSE out of range 1..255");
   end
   if (T_GAP < 1 || T_GAP > 255) begin : gen_bad_gap
      $error("T_GAP out of range 1..255");
   end

   // Timer reload values: a state lasting N cycles loads N-1. Setup gets one extra cycle
   // for the buffer's register stage, hence T_SETUP rather than T_SETUP-1.
   localparam logic [7:0] LdSetup = 8'(T_SETUP);
   localparam logic [7:0] LdPulse = 8'(T_PULSE - 1);
   localparam logic [7:0] LdGap   = 8'(T_GAP - 1);

   rtc_state_e state_q;
   logic       rw_q;
   logic [7:0] addr_q, wdata_q;
   logic       first_hold_q;
   logic       tmr_load, tmr_expire;
   logic [7:0] tmr_val;

   rtc_phase_timer u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   // Reload the timer on every transition into a timed state.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = 8'd0;
      case (state_q)
         StIdle:       begin tmr_load = req_i;      tmr_val = LdSetup; end
         StAddrSetup:  begin tmr_load = tmr_expire; tmr_val = LdPulse; end
         StAddrStrobe: begin tmr_load = tmr_expire; tmr_val = LdGap;   end
         StAddrHold:   begin tmr_load = tmr_expire; tmr_val = LdSetup; end
         StDataSetup:  begin tmr_load = tmr_expire; tmr_val = LdPulse; end
         StDataStrobe: begin tmr_load = tmr_expire; tmr_val = LdGap;   end
         default:      ;
      endcase
   end

   // Sequencer: outputs are registered and updated on the edge that enters each state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         rw_q         <= RW_WRITE;
         addr_q       <= 8'd0;
         wdata_q      <= 8'd0;
         first_hold_q <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         rdata_o      <= 8'd0;
         cs_n_o       <= 1'b1;
         rd_n_o       <= 1'b1;
         wr_n_o       <= 1'b1;
         ad_sel_o     <= AD_ADDR;
         buf_dir_o    <= DIR_RELEASE;
         buf_wdata_o  <= 8'd0;
      end else begin
         done_o       <= 1'b0;
         first_hold_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req_i) begin
                  rw_q        <= rw_i;
                  addr_q      <= addr_i;
                  wdata_q     <= wdata_i;
                  state_q     <= StAddrSetup;
                  busy_o      <= 1'b1;
                  cs_n_o      <= 1'b0;
                  ad_sel_o    <= AD_ADDR;
                  buf_dir_o   <= DIR_DRIVE;
                  buf_wdata_o <= addr_i;
               end
            end
            StAddrSetup: begin
               if (tmr_expire) begin
                  state_q <= StAddrStrobe;
                  wr_n_o  <= 1'b0;
               end
            end
            StAddrStrobe: begin
               if (tmr_expire) begin
                  state_q <= StAddrHold;
                  wr_n_o  <= 1'b1;
                  cs_n_o  <= 1'b1;
               end
            end
            StAddrHold: begin
               if (tmr_expire) begin
                  state_q  <= StDataSetup;
                  cs_n_o   <= 1'b0;
                  ad_sel_o <= AD_DATA;
                  if (rw_q == RW_READ) begin
                     buf_dir_o <= DIR_RELEASE;
                  end else begin
                     buf_dir_o   <= DIR_DRIVE;
                     buf_wdata_o <= wdata_q;
                  end
               end
            end
            StDataSetup: begin
               if (tmr_expire) begin
                  state_q <= StDataStrobe;
                  if (rw_q == RW_READ) rd_n_o <= 1'b0;
                  else                 wr_n_o <= 1'b0;
               end
            end
            StDataStrobe: begin
               if (tmr_expire) begin
                  state_q      <= StDataHold;
                  rd_n_o       <= 1'b1;
                  wr_n_o       <= 1'b1;
                  cs_n_o       <= 1'b1;
                  first_hold_q <= 1'b1;
               end
            end
            StDataHold: begin
               // buf_rdata lags the bus by one cycle, so the first hold cycle sees the
               // value from the last rd_n-low cycle.
               if (first_hold_q && (rw_q == RW_READ)) begin
                  rdata_o <= buf_rdata_i;
               end
               if (tmr_expire) begin
                  state_q   <= StDone;
                  done_o    <= 1'b1;
                  buf_dir_o <= DIR_RELEASE;
                  ad_sel_o  <= AD_ADDR;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_o  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
